encode_mul_arb: RTL
===================

# encode_mul_arb

Round-robin arbiter and sequencer that shares one pipelined signed-by-unsigned multiplier core among several requesters in the encoder datapath. It accepts operand pairs over valid/ready handshakes, drives the multiplier's clock-enable and operands, and tracks each issued operation's requester ID through the multiplier latency. It returns each product on a single response channel with backpressure. It sits between the encoder's MAC/scaling stages and the multiplier instance.

## Interface
- NREQ, 4: number of requesters, 2..8.
- A_W, 40: width of din0 operands, signed.
- B_W, 30: width of din1 operands, unsigned.
- P_W, 69: product width, matching the multiplier dout.
- MUL_LAT, 1: register stages inside the multiplier, 1..4. Each stage advances only while mul_ce is high.
- ID_W, $clog2(NREQ): width of the requester ID.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*A_W  packed signed operands; requester i occupies bits [i*A_W +: A_W].
- req_b  in  NREQ*B_W  packed unsigned operands.
- mul_ce  out  1  multiplier clock-enable.
- mul_din0  out  A_W  operand A to the multiplier.
- mul_din1  out  B_W  operand B to the multiplier.
- mul_dout  in  P_W  multiplier product.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  requester index of the response.
- rsp_data  out  P_W  product.
- stat_grant_cnt  out  NREQ*32  per-requester grant counters. Present only with ENCODE_MUL_ARB_STAT_EN.

## Operation
- Stall rule: stall = rsp_valid & ~rsp_ready, and mul_ce = ~stall. While mul_ce is low:
  - all req_ready outputs are 0;
  - the ID/valid pipeline, the multiplier and the response register hold their values.
- Arbitration:
  - Round-robin pointer ptr holds the last granted index.
  - The search starts at ptr+1 and wraps modulo NREQ.
  - The first requester with req_valid set is granted: req_ready[g]=1, combinationally, only when mul_ce=1.
  - ptr<=g on the cycle of the grant.
  - With no valid requester, ptr is unchanged.
- Operand mux: mul_din0/mul_din1 = req_a/req_b of the granted requester. With no grant they hold the operands of the last grant; no toggling is required.
- Tag pipeline: a MUL_LAT-deep shift register of {vld, id}.
  - Stage 0 loads {grant_any, g} on each mul_ce edge.
  - Each stage shifts on mul_ce edges.
  - It is aligned so that the final stage describes mul_dout in the current cycle.
- Response register: on each mul_ce edge:
  - rsp_valid <= last-stage vld;
  - rsp_id and rsp_data load only when that vld is 1.
- The response is consumed when rsp_valid & rsp_ready.
  - If a new product arrives on the same edge, it replaces the consumed one with no bubble.
  - If no product arrives, rsp_valid falls.
- Arithmetic is performed by the multiplier: product = signed(A) * signed({1'b0,B}), truncated to P_W LSBs. The block passes mul_dout through unmodified.
- Reset values:
  - req_ready = 0 while reset is high;
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0;
  - all tag-pipeline vld = 0;
  - ptr = NREQ-1, so requester 0 wins first;
  - mul_ce = 1.
- Reset mid-operation discards all in-flight operations. No responses are produced for them.

## Timing
- Accept at edge E (req_valid & req_ready) → rsp_valid high starting the cycle after edge E+MUL_LAT, i.e. MUL_LAT+1 cycles with no stalls.
- Throughput is one operation per cycle while rsp_ready stays high.
- Each stall cycle adds exactly one cycle to the latency of every in-flight operation. No operation is lost or duplicated.
- The order of responses equals the order of grants.
- rsp_valid, rsp_id and rsp_data stay stable while rsp_valid & ~rsp_ready.

## Configuration
- ENCODE_MUL_ARB_STAT_EN:
  - Defined: adds NREQ 32-bit counters. Counter i increments on each edge where req_valid[i] & req_ready[i]. Counters wrap at 2^32 and are cleared by reset.
  - Undefined: the stat_grant_cnt port and its logic are absent.

## Structure
- Shared package encode_mul_pkg holds:
  - localparams A_W=40, B_W=30, P_W=69;
  - typedef rsp_t {id, data};
  - the ID width function.
- One sub-module, encode_rr_arb: a parameterised round-robin arbiter with inputs req[NREQ] and en, outputs gnt one-hot and gnt_idx, and an internal ptr.

## Test plan
- Reset, then NREQ=4, MUL_LAT=1, only req 2 valid with A=-3, B=5 → req_ready=4'b0100 on the first cycle; rsp_valid 2 cycles later with rsp_id=2, rsp_data=-15 sign-extended to 69 bits.
- All four requests valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,…; responses back-to-back in the same ID order.
- A=-2^39, B=2^30-1 → rsp_data equals the 69-bit truncation of the exact product, checked against the reference model.
- rsp_ready held low for 5 cycles with the pipeline full → mul_ce=0 and req_ready=0 for those cycles; no response lost; same ID sequence after release.
- Reset asserted with 2 operations in flight → rsp_valid=0 the cycle after reset; no stale response afterwards; the next grant goes to req 0.
- With ENCODE_MUL_ARB_STAT_EN: 10 grants to req 1 and 3 grants to req 3 → stat_grant_cnt reads {3,0,10,0} (req 3 down to req 0); counter preloaded to 2^32-1 wraps to 0.

Source files
------------

// File: rtl/encode_mul_pkg.sv
// Shared definitions for the encoder multiplier arbiter: operand/product widths,
// response record and requester-ID width helper.
package encode_mul_pkg;

    localparam int A_W      = 40;
    localparam int B_W      = 30;
    localparam int P_W      = 69;
    localparam int MAX_NREQ = 8;

    typedef struct packed {
        logic [$clog2(MAX_NREQ)-1:0] id;
        logic [P_W-1:0]              data;
    } rsp_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/encode_rr_arb.sv
// Round-robin arbiter: search starts one past the last granted index and wraps;
// the grant is combinational and only asserted while en is high.
module encode_rr_arb
    import encode_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cand;
    logic            found;
    int              idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = ID_W'(idx);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (found && en) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= ID_W'(NREQ - 1);
        end else if (en && found) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/encode_mul_arb.sv
// Shares one pipelined signed x unsigned multiplier among NREQ requesters.
// Optional per-requester grant counters: define ENCODE_MUL_ARB_STAT_EN.
module encode_mul_arb
    import encode_mul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int A_W     = encode_mul_pkg::A_W,
    parameter int B_W     = encode_mul_pkg::B_W,
    parameter int P_W     = encode_mul_pkg::P_W,
    parameter int MUL_LAT = 1,
    parameter int ID_W    = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*A_W-1:0]   req_a,
    input  logic [NREQ*B_W-1:0]   req_b,
    output logic                  mul_ce,
    output logic signed [A_W-1:0] mul_din0,
    output logic [B_W-1:0]        mul_din1,
    input  logic signed [P_W-1:0] mul_dout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
`ifdef ENCODE_MUL_ARB_STAT_EN
    output logic [NREQ*32-1:0]    stat_grant_cnt,
`endif
    output logic signed [P_W-1:0] rsp_data
);

    logic                  arb_en;
    logic                  grant_any;
    logic [NREQ-1:0]       gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic signed [A_W-1:0] last_a;
    logic [B_W-1:0]        last_b;
    logic [MUL_LAT-1:0]    vld_p;
    logic [ID_W-1:0]       id_p [MUL_LAT];

    // A held response freezes the whole multiplier path.
    assign mul_ce    = reset | ~(rsp_valid & ~rsp_ready);
    assign arb_en    = mul_ce & ~reset;
    assign grant_any = |gnt;
    assign req_ready = gnt;

    encode_rr_arb #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        mul_din0 = last_a;
        mul_din1 = last_b;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mul_din0 = $signed(req_a[i*A_W +: A_W]);
                mul_din1 = req_b[i*B_W +: B_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant_any) begin
            last_a <= mul_din0;
            last_b <= mul_din1;
        end
    end

    // Tag stages p0..p(MUL_LAT-1), in lockstep with the multiplier registers
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
        end else if (mul_ce) begin
            vld_p[0] <= grant_any;
            for (int i = 1; i < MUL_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (mul_ce) begin
            id_p[0] <= gnt_idx;
            for (int i = 1; i < MUL_LAT; i++) id_p[i] <= id_p[i-1];
        end
    end

    // Response register: last tag stage describes mul_dout this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (mul_ce) begin
            rsp_valid <= vld_p[MUL_LAT-1];
            if (vld_p[MUL_LAT-1]) begin
                rsp_id   <= id_p[MUL_LAT-1];
                rsp_data <= mul_dout;
            end
        end
    end

`ifdef ENCODE_MUL_ARB_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] & req_ready[i])
                    stat_grant_cnt[i*32 +: 32] <= stat_grant_cnt[i*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule
